// File: rtl/wb_regfile_commit_if.sv
// rtl/wb_regfile_commit_if.sv - W-stage writeback bundle and ID-stage read ports
interface wb_regfile_commit_if #(
    parameter int XLEN = 32
);
    logic            RegWriteW;
    logic [4:0]      rdW;
    logic [1:0]      MemtoRegW;
    logic [XLEN-1:0] ResultW;
    logic [XLEN-1:0] MemDataW;
    logic [XLEN-1:0] PCW;
    logic [31:0]     InsW;
    logic            commit_en;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] wb_data;

    modport master (
        output RegWriteW, rdW, MemtoRegW, ResultW, MemDataW, PCW, InsW, commit_en,
        output rs1, rs2,
        input  rd1, rd2, wb_data
    );

    modport slave (
        input  RegWriteW, rdW, MemtoRegW, ResultW, MemDataW, PCW, InsW, commit_en,
        input  rs1, rs2,
        output rd1, rd2, wb_data
    );
endinterface

// File: rtl/wb_regfile_commit.sv
// rtl/wb_regfile_commit.sv - writeback select, 32x32 register file with bypass, retire counter
// Optional macro WB_TRACE_EN adds registered retire trace outputs.
module wb_regfile_commit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_regfile_commit_if.slave   bus,
    output logic                 retire,
    output logic [CNT_W-1:0]     instret
`ifdef WB_TRACE_EN
    ,
    output logic                 trace_valid,
    output logic [XLEN-1:0]      trace_pc,
    output logic [31:0]          trace_ins,
    output logic [XLEN-1:0]      trace_wdata
`endif
);

    logic [XLEN-1:0] regs [1:31];
    logic [XLEN-1:0] wb_data;
    logic            we;
    logic            count;

    assign we    = bus.RegWriteW && (bus.rdW != 5'd0);
    assign count = bus.commit_en && (bus.InsW != 32'd0);

    always_comb begin
        wb_data = bus.ResultW;
        case (bus.MemtoRegW)
            2'b01:   wb_data = bus.MemDataW;
            2'b10:   wb_data = bus.PCW + XLEN'(4);
            default: wb_data = bus.ResultW;
        endcase
    end

    assign bus.wb_data = wb_data;

    // x0 has no storage; the 1..31 array keeps it hard-wired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[bus.rdW] <= wb_data;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        if (bus.rs1 != 5'd0) begin
            if (we && (bus.rs1 == bus.rdW)) bus.rd1 = wb_data;
            else                            bus.rd1 = regs[bus.rs1];
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.rs2 != 5'd0) begin
            if (we && (bus.rs2 == bus.rdW)) bus.rd2 = wb_data;
            else                            bus.rd2 = regs[bus.rs2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire  <= 1'b0;
            instret <= '0;
        end else begin
            retire <= count;
            if (count) instret <= instret + CNT_W'(1);
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_ins   <= '0;
            trace_wdata <= '0;
        end else begin
            trace_valid <= count;
            if (count) begin
                trace_pc    <= bus.PCW;
                trace_ins   <= bus.InsW;
                trace_wdata <= we ? wb_data : '0;
            end
        end
    end
`endif

endmodule
